coklu_toplama: RTL and testbench



---
 rtl/coklu_toplama.sv | 119 +++++++++++
 tb/tb_coklu_toplama.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/coklu_toplama.sv
// Multi-cycle adder: sums M operands of N bits using K lane accumulators.
// Result is valid C+1 edges after acceptance; accepts only when idle and holds the result until consumed.
module coklu_toplama #(
    parameter int N = 8,
    parameter int M = 10,
    parameter int K = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      giris_etkin,
    output logic                      hazir,
    input  logic                      isaretli,
    input  logic [M*N-1:0]            sayilar,
    output logic [N+$clog2(M)-1:0]    sonuc,
    output logic                      sonuc_etkin,
    input  logic                      sonuc_al
);

    localparam int W  = N + $clog2(M);
    localparam int C  = (M + K - 1) / K;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    localparam logic [1:0] BOS       = 2'd0;
    localparam logic [1:0] TOPLA     = 2'd1;
    localparam logic [1:0] BIRLESTIR = 2'd2;
    localparam logic [1:0] SONUC     = 2'd3;

    logic [1:0]     r_state;
    logic [M*N-1:0] r_sayilar;
    logic           r_isaretli;
    logic [CW-1:0]  r_c;
    logic [W-1:0]   r_acc [K];
    logic [W-1:0]   r_sonuc;
    logic           r_sonuc_etkin;

    logic [W-1:0]   w_ext     [M];
    logic [W-1:0]   w_lane_op [K];
    logic [W-1:0]   w_toplam;

    // Sign bit only propagates when the latched mode is signed.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            w_ext[i] = {{(W-N){r_isaretli & r_sayilar[i*N+N-1]}}, r_sayilar[i*N +: N]};
        end
    end

    // Lane j picks operand c*K+j; slots past the last operand stay zero.
    always_comb begin
        for (int j = 0; j < K; j++) begin
            w_lane_op[j] = '0;
            for (int i = 0; i < M; i++) begin
                if (i == int'(r_c) * K + j) begin
                    w_lane_op[j] = w_ext[i];
                end
            end
        end
    end

    always_comb begin
        w_toplam = '0;
        for (int j = 0; j < K; j++) begin
            w_toplam = w_toplam + r_acc[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOS;
            r_sayilar     <= '0;
            r_isaretli    <= 1'b0;
            r_c           <= '0;
            r_sonuc       <= '0;
            r_sonuc_etkin <= 1'b0;
            for (int j = 0; j < K; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            case (r_state)
                BOS: begin
                    if (giris_etkin) begin
                        r_sayilar  <= sayilar;
                        r_isaretli <= isaretli;
                        r_c        <= '0;
                        for (int j = 0; j < K; j++) begin
                            r_acc[j] <= '0;
                        end
                        r_state    <= TOPLA;
                    end
                end
                TOPLA: begin
                    for (int j = 0; j < K; j++) begin
                        r_acc[j] <= r_acc[j] + w_lane_op[j];
                    end
                    r_c <= r_c + 1'b1;
                    if (r_c == CW'(C - 1)) begin
                        r_state <= BIRLESTIR;
                    end
                end
                BIRLESTIR: begin
                    r_sonuc       <= w_toplam;
                    r_sonuc_etkin <= 1'b1;
                    r_state       <= SONUC;
                end
                SONUC: begin
                    if (sonuc_al) begin
                        r_sonuc_etkin <= 1'b0;
                        r_state       <= BOS;
                    end
                end
                default: r_state <= BOS;
            endcase
        end
    end

    assign hazir       = (r_state == BOS);
    assign sonuc       = r_sonuc;
    assign sonuc_etkin = r_sonuc_etkin;

endmodule

// File: tb/tb_coklu_toplama.sv
// Scoreboard bench: two adders (K=2 and K=3) share inputs; a monitor checks each result handshake.
module tb_coklu_toplama;

    logic        clk;
    logic        rst_n;
    logic        giris_etkin;
    logic        isaretli;
    logic [79:0] sayilar;
    logic        sonuc_al;
    logic        hazir2, hazir3;
    logic [11:0] sonuc2, sonuc3;
    logic        sonuc_etkin2, sonuc_etkin3;

    int total = 0;
    int bad   = 0;
    logic [11:0] q2[$];
    logic [11:0] q3[$];

    coklu_toplama #(.N(8), .M(10), .K(2)) u_k2 (
        .clk(clk), .rst_n(rst_n), .giris_etkin(giris_etkin), .hazir(hazir2),
        .isaretli(isaretli), .sayilar(sayilar), .sonuc(sonuc2),
        .sonuc_etkin(sonuc_etkin2), .sonuc_al(sonuc_al)
    );

    coklu_toplama #(.N(8), .M(10), .K(3)) u_k3 (
        .clk(clk), .rst_n(rst_n), .giris_etkin(giris_etkin), .hazir(hazir3),
        .isaretli(isaretli), .sayilar(sayilar), .sonuc(sonuc3),
        .sonuc_etkin(sonuc_etkin3), .sonuc_al(sonuc_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] fill(input logic [7:0] a, input logic [7:0] b);
        logic [79:0] v;
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = (i % 2 == 0) ? a : b;
        return v;
    endfunction

    function automatic logic [79:0] seq();
        logic [79:0] v;
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(i + 1);
        return v;
    endfunction

    // Monitor: a handshake seen at negedge completes on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && sonuc_al) begin
                if (sonuc_etkin2) begin
                    if (q2.size() == 0) begin
                        total++; bad++;
                        $display("FAIL res_k2 unexpected actual=%0h required=none", sonuc2);
                    end else chk("res_k2", 32'(sonuc2), 32'(q2.pop_front()));
                end
                if (sonuc_etkin3) begin
                    if (q3.size() == 0) begin
                        total++; bad++;
                        $display("FAIL res_k3 unexpected actual=%0h required=none", sonuc3);
                    end else chk("res_k3", 32'(sonuc3), 32'(q3.pop_front()));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!(hazir2 && hazir3) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(hazir2 && hazir3)) begin
            total++; bad++;
            $display("FAIL wait_ready actual=%0b%0b required=11", hazir2, hazir3);
        end
    endtask

    task automatic send(input logic [79:0] ops, input logic sgn, input logic [11:0] exp);
        int lat2 = 0;
        int lat3 = 0;
        logic hz_ok = 1'b1;
        wait_ready();
        sayilar = ops; isaretli = sgn; giris_etkin = 1'b1;
        @(posedge clk); #1;
        giris_etkin = 1'b0;
        sayilar = ~ops; isaretli = ~sgn;
        q2.push_back(exp); q3.push_back(exp);
        chk("hazir_after_accept", 32'({hazir2, hazir3}), 32'd0);
        for (int e = 1; e <= 20 && (lat2 == 0 || lat3 == 0); e++) begin
            @(posedge clk); #1;
            if (lat2 == 0 && !sonuc_etkin2 && hazir2) hz_ok = 1'b0;
            if (lat2 == 0 && sonuc_etkin2) lat2 = e;
            if (lat3 == 0 && sonuc_etkin3) lat3 = e;
        end
        chk("latency_k2", 32'(lat2), 32'd6);
        chk("latency_k3", 32'(lat3), 32'd5);
        chk("hazir_low_busy", 32'(hz_ok), 32'd1);
        if (sonuc_al) begin
            @(posedge clk); #1;
            chk("etkin_k2_after_take", 32'(sonuc_etkin2), 32'd0);
            chk("hazir_k2_after_take", 32'(hazir2), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; giris_etkin = 1'b0; isaretli = 1'b0; sayilar = '0; sonuc_al = 1'b1;
        #3;
        chk("rst_sonuc", 32'({sonuc2, sonuc3}), 32'd0);
        chk("rst_etkin", 32'({sonuc_etkin2, sonuc_etkin3}), 32'd0);
        chk("rst_hazir", 32'({hazir2, hazir3}), 32'd3);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        send(fill(8'hFF, 8'hFF), 1'b0, 12'h9F6);
        send(fill(8'h80, 8'h80), 1'b1, 12'hB00);
        send(fill(8'h7F, 8'h80), 1'b1, 12'hFFB);
        send(seq(),              1'b0, 12'd55);
        send(fill(8'h80, 8'h80), 1'b0, 12'h500);

        // Consumer stalls; result must hold and new bundles must be ignored.
        sonuc_al = 1'b0;
        send(fill(8'hFF, 8'hFF), 1'b1, 12'hFF6);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            giris_etkin = (k % 2 == 0) && (k < 9);
            chk("hold_sonuc_k2", 32'(sonuc2), 32'hFF6);
            chk("hold_sonuc_k3", 32'(sonuc3), 32'hFF6);
            chk("hold_etkin", 32'({sonuc_etkin2, sonuc_etkin3}), 32'd3);
            chk("hold_hazir", 32'({hazir2, hazir3}), 32'd0);
        end
        giris_etkin = 1'b0;
        sonuc_al = 1'b1;
        @(posedge clk); #1;
        sonuc_al = 1'b0;
        chk("take_etkin", 32'({sonuc_etkin2, sonuc_etkin3}), 32'd0);
        chk("take_hazir", 32'({hazir2, hazir3}), 32'd3);
        chk("take_keep_sonuc", 32'(sonuc2), 32'hFF6);
        @(posedge clk); #1;
        chk("idle_no_accept", 32'({hazir2, hazir3}), 32'd3);
        sonuc_al = 1'b1;

        // Reset in the middle of accumulation.
        wait_ready();
        sayilar = fill(8'h80, 8'h80); isaretli = 1'b1; giris_etkin = 1'b1;
        @(posedge clk); #1; giris_etkin = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sonuc", 32'({sonuc2, sonuc3}), 32'd0);
        chk("midrst_etkin", 32'({sonuc_etkin2, sonuc_etkin3}), 32'd0);
        chk("midrst_hazir", 32'({hazir2, hazir3}), 32'd3);
        @(posedge clk); #1; rst_n = 1'b1;
        send(seq(), 1'b0, 12'd55);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q2.size() + q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
